// File: rtl/sevenseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl
//
// Multiplexed seven-segment scan controller. A load-strobed shadow register
// holds the packed BCD word and decimal-point requests; a free-running refresh
// counter advances a digit index every REFRESH_DIV cycles, and the selected
// digit is decoded into registered, active-low segment/dp outputs plus a
// one-hot, active-high digit enable.
//
// Parameters:
//   NUM_DIGITS   number of multiplexed digits (1..8)
//   REFRESH_DIV  clock cycles each digit stays active (>= 2)
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   load    in   latch bcd_in/dp_in into the shadow register
//   bcd_in  in   packed BCD, bits [4k+3:4k] = digit k, digit 0 rightmost
//   dp_in   in   per-digit decimal point request, 1 = lit
//   enable  in   1 = display on, 0 = all digits off (scan keeps running)
//   seg     out  segments {a,b,c,d,e,f,g}, active-low
//   dp      out  decimal point, active-low
//   dig     out  one-hot digit enable, active-high
//
// Build option:
//   SEVSEG_LZ_BLANK_EN  when defined, leading zeros (with no decimal point
//                       requested) are blanked; digit 0 is never blanked.
// ---------------------------------------------------------------------------
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      enable,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     dig
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] bcd_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_code;
    logic                    cur_dp_req;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cur_onehot;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_OFF;    // codes 10..15 show blank
        endcase
    endfunction

    // Leading-zero mask: digit k is blank when it and every digit above it
    // hold 0 with no decimal point requested. Scanning from the top digit
    // down, the running AND breaks at the first significant digit.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        lz_blank = '0;
`ifdef SEVSEG_LZ_BLANK_EN
        begin
            logic lz_run;
            lz_run = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                lz_run      = lz_run & (bcd_sh[4*k +: 4] == 4'd0) & ~dp_sh[k];
                lz_blank[k] = lz_run;
            end
        end
`endif
    end

    // Select the active digit's code, dp request and blanking flag.
    always_comb begin
        cur_code   = 4'd0;
        cur_dp_req = 1'b0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_code      = bcd_sh[4*k +: 4];
                cur_dp_req    = dp_sh[k];
                cur_blank     = lz_blank[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_sh <= '0;
            dp_sh  <= '0;
            cnt    <= '0;
            idx    <= '0;
            seg    <= SEG_OFF;
            dp     <= 1'b1;
            dig    <= '0;
        end else begin
            if (load) begin
                bcd_sh <= bcd_in;
                dp_sh  <= dp_in;
            end

            // The scan runs regardless of enable so re-enabling stays in phase.
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Outputs reflect the state present before this edge, giving a
            // fixed one-cycle latency from shadow/index to the pins.
            if (!enable) begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                dig <= '0;
            end else if (cur_blank) begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                dig <= cur_onehot;
            end else begin
                seg <= decode(cur_code);
                dp  <= ~cur_dp_req;
                dig <= cur_onehot;
            end
        end
    end

endmodule
